// File: rtl/alu_cmd_sequencer_if.sv
// Selector/operand bus between the command sequencer (master) and the 8-bit accumulator ALU (slave).
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       in_selector;
  logic [6:0]       out_selector;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [WIDTH-1:0] alu_result;
  logic [1:0]       alu_state;

  modport master (
    output in_selector,
    output out_selector,
    output num1,
    output num2,
    input  alu_result,
    input  alu_state
  );

  modport slave (
    input  in_selector,
    input  out_selector,
    input  num1,
    input  num2,
    output alu_result,
    output alu_state
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Runs a small program of ALU instructions over the selector/operand bus and captures each result.
// Defining ALU_SEQ_STEP_EN adds a step input and a PAUSE state for single-stepping.
module alu_cmd_sequencer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [2*WIDTH+4:0]       prog_data,
  input  logic                     start,
  input  logic                     clear,
`ifdef ALU_SEQ_STEP_EN
  input  logic                     step,
`endif
  alu_cmd_sequencer_if.master      alu,
  output logic [WIDTH-1:0]         result,
  output logic                     res_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = 2*WIDTH+5;
  localparam logic [2:0] OP_HALT     = 3'd7;
  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_RESET   = 3'b001;
  localparam logic [6:0] OSEL_AND    = 7'b1000000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
`ifdef ALU_SEQ_STEP_EN
    , S_PAUSE = 3'd5
`endif
  } state_e;

  function automatic logic [2:0] ld_onehot(input logic [1:0] mode);
    case (mode)
      2'd1:    ld_onehot = 3'b010;
      2'd2:    ld_onehot = 3'b001;
      default: ld_onehot = 3'b100;
    endcase
  endfunction

  function automatic logic [6:0] op_onehot(input logic [2:0] op);
    case (op)
      3'd0:    op_onehot = 7'b1000000;
      3'd1:    op_onehot = 7'b0100000;
      3'd2:    op_onehot = 7'b0010000;
      3'd3:    op_onehot = 7'b0001000;
      3'd4:    op_onehot = 7'b0000100;
      3'd5:    op_onehot = 7'b0000010;
      3'd6:    op_onehot = 7'b0000001;
      default: op_onehot = OSEL_AND;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       in_sel_q, in_sel_d;
  logic [6:0]       out_sel_q, out_sel_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;

  logic [IW-1:0]    mem_q [DEPTH];
  logic             mem_we_s;
  logic [AW-1:0]    fetch_addr_s;
  logic [IW-1:0]    fetch_s;
  logic [2:0]       cur_op_s;

  assign mem_we_s = prog_we && (state_q == S_IDLE);
  assign cur_op_s = mem_q[pc_q][IW-3:IW-5];

  // Program store; writes accepted only while idle, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Instruction about to be issued, forwarding a same-cycle write so entry 0 is fresh at start.
  always_comb begin
    fetch_addr_s = '0;
    fetch_s      = '0;
    if (state_q == S_IDLE) begin
      fetch_addr_s = '0;
    end else begin
      fetch_addr_s = pc_q + AW'(1);
    end
    if (mem_we_s && (prog_addr == fetch_addr_s)) begin
      fetch_s = prog_data;
    end else begin
      fetch_s = mem_q[fetch_addr_s];
    end
  end

  // Next-state, program counter and result capture.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    result_d    = result_q;
    res_valid_d = 1'b0;
    out_sel_d   = out_sel_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          pc_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cur_op_s == OP_HALT) begin
          state_d = S_DONE;
          // pc reports the last instruction that actually ran, not the HALT slot.
          if (pc_q == '0) begin
            pc_d = '0;
          end else begin
            pc_d = pc_q - AW'(1);
          end
        end else begin
          state_d   = S_WAIT;
          out_sel_d = op_onehot(cur_op_s);
        end
      end
      S_WAIT: begin
        if (alu.alu_state == 2'b11) begin
          state_d = S_ERROR;
        end else begin
          result_d    = alu.alu_result;
          res_valid_d = 1'b1;
          if (pc_q == AW'(DEPTH-1)) begin
            state_d = S_DONE;
          end else begin
`ifdef ALU_SEQ_STEP_EN
            state_d = S_PAUSE;
`else
            state_d = S_ISSUE;
            pc_d    = pc_q + AW'(1);
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (clear) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ERROR;
        end
      end
`ifdef ALU_SEQ_STEP_EN
      S_PAUSE: begin
        if (step) begin
          state_d = S_ISSUE;
          pc_d    = pc_q + AW'(1);
        end else begin
          state_d = S_PAUSE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus and status values for the cycle after the edge, derived from where the FSM is heading.
  always_comb begin
    in_sel_d = SEL_PERSIST;
    num1_d   = num1_q;
    num2_d   = num2_q;
    if ((state_d == S_ISSUE) && (fetch_s[IW-3:IW-5] != OP_HALT)) begin
      in_sel_d = ld_onehot(fetch_s[IW-1:IW-2]);
      num1_d   = fetch_s[2*WIDTH-1:WIDTH];
      num2_d   = fetch_s[WIDTH-1:0];
    end else begin
      in_sel_d = SEL_PERSIST;
      num1_d   = num1_q;
      num2_d   = num2_q;
    end
    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
  end

  // State and output registers; reset parks the ALU in its clear selection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      in_sel_q    <= SEL_RESET;
      out_sel_q   <= OSEL_AND;
      num1_q      <= '0;
      num2_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      in_sel_q    <= in_sel_d;
      out_sel_q   <= out_sel_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
    end
  end

  assign alu.in_selector  = in_sel_q;
  assign alu.out_selector = out_sel_q;
  assign alu.num1         = num1_q;
  assign alu.num2         = num2_q;
  assign result           = result_q;
  assign res_valid        = res_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign pc               = pc_q;
endmodule
